// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MIPS byte/halfword/word load-store unit in front of a word-wide data RAM
// Sub-word stores are read-modify-write; misaligned requests respond with addr_err and never touch RAM.
module mem_access_unit #(
    parameter int unsigned ADDR_W     = 32,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [2:0]        i_op,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_store_data,
    output logic              o_resp_valid,
    output logic [31:0]       o_load_data,
    output logic              o_addr_err,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic [31:0]       o_ram_wdata,
    input  logic [31:0]       i_ram_rdata
);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LBU = 3'b001;
    localparam logic [2:0] OP_LH  = 3'b010;
    localparam logic [2:0] OP_LHU = 3'b011;
    localparam logic [2:0] OP_LW  = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_WRITE,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_sdata;
    logic [31:0]         r_load_data;
    logic                r_addr_err;
    logic [31:0]         r_ram_wdata;

    logic                w_accept;
    logic                w_misalign;
    logic [4:0]          w_byte_sh;
    logic [4:0]          w_half_sh;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load_ext;
    logic [31:0]         w_merge_b;
    logic [31:0]         w_merge_h;

    assign w_accept = i_req_valid && (r_state == S_IDLE);

    // Alignment is judged on the request inputs so a bad address can skip straight to RESP.
    always_comb begin
        w_misalign = 1'b0;
        case (i_op)
            OP_LH, OP_LHU, OP_SH: w_misalign = i_addr[0];
            OP_LW, OP_SW:         w_misalign = |i_addr[1:0];
            default:              w_misalign = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_misalign) begin
                        w_next = S_RESP;
                    end else if (i_op <= OP_LW) begin
                        w_next = S_LOAD;
                    end else if (i_op == OP_SW) begin
                        w_next = S_WRITE;
                    end else begin
                        w_next = S_RMW_RD;
                    end
                end
            end
            S_LOAD:   w_next = S_RESP;
            S_RMW_RD: w_next = S_WRITE;
            S_WRITE:  w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Lane shift amounts; big-endian mirrors the lane index within the word.
    assign w_byte_sh = BIG_ENDIAN ? {~r_addr[1:0], 3'b000} : {r_addr[1:0], 3'b000};
    assign w_half_sh = BIG_ENDIAN ? {~r_addr[1], 4'b0000} : {r_addr[1], 4'b0000};

    assign w_byte = i_ram_rdata[w_byte_sh +: 8];
    assign w_half = i_ram_rdata[w_half_sh +: 16];

    always_comb begin
        w_load_ext = i_ram_rdata;
        case (r_op)
            OP_LB:   w_load_ext = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load_ext = {24'h000000, w_byte};
            OP_LH:   w_load_ext = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_load_ext = {16'h0000, w_half};
            default: w_load_ext = i_ram_rdata;
        endcase
    end

    assign w_merge_b = (i_ram_rdata & ~(32'h0000_00FF << w_byte_sh))
                     | ({24'h000000, r_sdata[7:0]} << w_byte_sh);
    assign w_merge_h = (i_ram_rdata & ~(32'h0000_FFFF << w_half_sh))
                     | ({16'h0000, r_sdata} << w_half_sh);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op        <= 3'b000;
            r_addr      <= '0;
            r_sdata     <= 16'h0000;
            r_load_data <= 32'h0000_0000;
            r_addr_err  <= 1'b0;
            r_ram_wdata <= 32'h0000_0000;
        end else begin
            if (w_accept) begin
                r_op        <= i_op;
                r_addr      <= i_addr;
                r_sdata     <= i_store_data[15:0];
                r_load_data <= 32'h0000_0000;
                r_addr_err  <= w_misalign;
                if ((i_op == OP_SW) && !w_misalign) begin
                    r_ram_wdata <= i_store_data;
                end
            end
            if (r_state == S_LOAD) begin
                r_load_data <= w_load_ext;
            end
            if (r_state == S_RMW_RD) begin
                r_ram_wdata <= (r_op == OP_SB) ? w_merge_b : w_merge_h;
            end
        end
    end

    assign o_req_ready  = (r_state == S_IDLE);
    assign o_resp_valid = (r_state == S_RESP);
    assign o_ram_we     = (r_state == S_WRITE);
    assign o_load_data  = r_load_data;
    assign o_addr_err   = r_addr_err;
    assign o_ram_wdata  = r_ram_wdata;
    assign o_ram_addr   = {r_addr[ADDR_W-1:2], 2'b00};

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  op = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] sdata = 32'h0;
    logic        resp_valid;
    logic [31:0] load_data;
    logic        addr_err;
    logic [31:0] ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0] mem [0:63];
    int          we_cnt = 0;
    logic [31:0] we_addr = 32'h0;
    logic [31:0] we_data = 32'h0;

    int          total = 0;
    int          bad = 0;
    int          r_lat;
    logic [31:0] r_ld;
    logic        r_err;
    logic        r_busy_ready;
    int          r_we;
    int          we_mark;

    localparam logic [2:0] LB = 3'b000, LBU = 3'b001, LH = 3'b010, LHU = 3'b011;
    localparam logic [2:0] LW = 3'b100, SB = 3'b101, SH = 3'b110, SW = 3'b111;

    mem_access_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b0)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_op         (op),
        .i_addr       (addr),
        .i_store_data (sdata),
        .o_resp_valid (resp_valid),
        .o_load_data  (load_data),
        .o_addr_err   (addr_err),
        .o_ram_addr   (ram_addr),
        .o_ram_we     (ram_we),
        .o_ram_wdata  (ram_wdata),
        .i_ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr[7:2]];

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr[7:2]] <= ram_wdata;
            we_cnt  <= we_cnt + 1;
            we_addr <= ram_addr;
            we_data <= ram_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
        int cyc;
        @(negedge clk);
        req_valid = 1'b1;
        op = o;
        addr = a;
        sdata = d;
        we_mark = we_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        addr = ~a;
        sdata = ~d;
        r_lat = 99;
        r_ld = 32'hxxxx_xxxx;
        r_err = 1'bx;
        r_busy_ready = 1'bx;
        cyc = 1;
        while (cyc <= 8) begin
            @(negedge clk);
            if (cyc == 1) r_busy_ready = req_ready;
            if (resp_valid) begin
                r_lat = cyc;
                r_ld = load_data;
                r_err = addr_err;
                break;
            end
            cyc++;
        end
        r_we = we_cnt - we_mark;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp", 32'(resp_valid), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", ram_addr, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_wdata", ram_wdata, 32'h0);
        chk("rst_err", 32'(addr_err), 32'd0);
        rst_n = 1'b1;

        do_req(SW, 32'h10, 32'hDEADBEEF);
        chk("sw_lat", r_lat, 2);
        chk("sw_busy_ready", 32'(r_busy_ready), 32'd0);
        chk("sw_we_cnt", r_we, 1);
        chk("sw_we_addr", we_addr, 32'h10);
        chk("sw_ld_zero", r_ld, 32'h0);
        do_req(LW, 32'h10, 32'h0);
        chk("lw_lat", r_lat, 2);
        chk("lw_data", r_ld, 32'hDEADBEEF);
        chk("lw_err", 32'(r_err), 32'd0);

        do_req(SW, 32'h10, 32'h80FF7F01);
        do_req(LB, 32'h13, 32'h0);
        chk("lb13", r_ld, 32'hFFFFFF80);
        chk("lb_lat", r_lat, 2);
        do_req(LBU, 32'h13, 32'h0);
        chk("lbu13", r_ld, 32'h00000080);
        do_req(LB, 32'h11, 32'h0);
        chk("lb11", r_ld, 32'h0000007F);
        do_req(LH, 32'h12, 32'h0);
        chk("lh12", r_ld, 32'hFFFF80FF);
        do_req(LHU, 32'h12, 32'h0);
        chk("lhu12", r_ld, 32'h000080FF);
        do_req(LH, 32'h10, 32'h0);
        chk("lh10", r_ld, 32'h00007F01);

        do_req(SB, 32'h11, 32'hFFFFFFAB);
        chk("sb_lat", r_lat, 3);
        chk("sb_we_cnt", r_we, 1);
        chk("sb_wdata", we_data, 32'h80FFAB01);
        chk("sb_ld_zero", r_ld, 32'h0);
        do_req(LW, 32'h10, 32'h0);
        chk("sb_readback", r_ld, 32'h80FFAB01);
        do_req(SH, 32'h12, 32'h55551234);
        chk("sh_lat", r_lat, 3);
        chk("sh_we_cnt", r_we, 1);
        chk("sh_we_addr", we_addr, 32'h10);
        do_req(LW, 32'h10, 32'h0);
        chk("sh_readback", r_ld, 32'h1234AB01);

        do_req(LW, 32'h11, 32'h0);
        chk("mis_lw_lat", r_lat, 1);
        chk("mis_lw_err", 32'(r_err), 32'd1);
        chk("mis_lw_ld", r_ld, 32'h0);
        do_req(SH, 32'h13, 32'hFFFF);
        chk("mis_sh_lat", r_lat, 1);
        chk("mis_sh_err", 32'(r_err), 32'd1);
        chk("mis_sh_we", r_we, 0);
        do_req(LH, 32'h01, 32'h0);
        chk("mis_lh_lat", r_lat, 1);
        chk("mis_lh_err", 32'(r_err), 32'd1);
        do_req(LW, 32'h10, 32'h0);
        chk("mis_mem_kept", r_ld, 32'h1234AB01);

        do_req(SW, 32'hFFFFFFFC, 32'hCAFEF00D);
        chk("top_we_addr", we_addr, 32'hFFFFFFFC);
        do_req(LW, 32'hFFFFFFFC, 32'h0);
        chk("top_ld", r_ld, 32'hCAFEF00D);
        chk("top_ram_addr", ram_addr, 32'hFFFFFFFC);

        do_req(SW, 32'h14, 32'h11223344);
        @(negedge clk);
        req_valid = 1'b1;
        op = SB;
        addr = 32'h15;
        sdata = 32'hAA;
        we_mark = we_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rmw_busy", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rmw_rst_we", 32'(ram_we), 32'd0);
        chk("rmw_rst_ready", 32'(req_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rmw_rst_no_we", we_cnt - we_mark, 0);
        chk("rmw_rel_ready", 32'(req_ready), 32'd1);
        chk("rmw_rel_resp", 32'(resp_valid), 32'd0);
        do_req(LW, 32'h14, 32'h0);
        chk("rmw_mem_kept", r_ld, 32'h11223344);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the multicycle CPU datapath and the word-organised data RAM. The RAM has a 32-bit read port, a synchronous 32-bit full-word write, and no byte enables.
- Performs MIPS byte, halfword and word loads with sign/zero extension.
- Performs SW as a direct write. Performs SB/SH as a read-modify-write sequence, driven by a small FSM with a valid/ready request and a one-cycle response pulse.
- Flags misaligned accesses instead of touching RAM.

Parameters:
- ADDR_W, 32, width of addr and ram_addr.
- BIG_ENDIAN, 0, byte-lane order. 0: byte 0 = bits[7:0]. 1: byte 0 = bits[31:24].

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept.
- op  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW.
- addr  in  ADDR_W  byte address.
- store_data  in  32  store operand; SB uses [7:0], SH uses [15:0].
- resp_valid  out  1  one-cycle completion pulse.
- load_data  out  32  extended load result, valid while resp_valid.
- addr_err  out  1  misalignment flag, valid while resp_valid.
- ram_addr  out  ADDR_W  byte address to RAM, low two bits forced 0.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  32  RAM write word.
- ram_rdata  in  32  RAM combinational read data for ram_addr.

Behaviour:
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- Reset (async, rst_n=0):
  - state=IDLE.
  - resp_valid=0, load_data=0, addr_err=0, ram_we=0, ram_wdata=0, ram_addr=0.
  - Latched op/addr/data cleared.
  - A reset mid-operation aborts with no write. ram_we is decoded from state, so it drops immediately.
- IDLE:
  - req_ready=1 only in IDLE.
  - Handshake: req_valid and req_ready at a rising edge latch op, addr and store_data.
- Misalignment check on the latched request:
  - LH, LHU, SH: addr[0]!=0 is misaligned.
  - LW, SW: addr[1:0]!=0 is misaligned.
  - Byte ops never misalign.
  - A misaligned request goes straight to RESP with addr_err=1, load_data=0 and no RAM write.
- Aligned transitions from IDLE:
  - Loads go to LOAD.
  - SW goes to WRITE, with ram_wdata=store_data.
  - SB and SH go to RMW_RD.
- ram_addr = {latched addr[ADDR_W-1:2], 2'b00} in every non-IDLE state. It holds its last value in IDLE.
- LOAD, one cycle:
  - ram_rdata is sampled at the end of the cycle.
  - The byte/halfword at the lane selected by addr[1:0] / addr[1] is extracted.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes through.
  - Result goes to the load_data register, then next state is RESP.
- RMW_RD, one cycle:
  - Sample ram_rdata.
  - Replace the selected byte (SB) or halfword (SH) lane with store_data[7:0] or [15:0].
  - Result goes to the ram_wdata register, then next state is WRITE.
- WRITE, one cycle:
  - ram_we=1 for exactly this cycle, and nowhere else.
  - Next state is RESP.
- RESP, one cycle:
  - resp_valid=1.
  - Stores give load_data=0 and addr_err=0.
  - Next state is IDLE. Back-to-back requests are therefore separated by at least one IDLE cycle.
- Latency from the handshake edge to resp_valid high:
  - Misaligned: 1 cycle.
  - Load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
- Boundary conditions:
  - req_valid while not IDLE is ignored; the requester must hold it.
  - addr and store_data changing after the handshake have no effect.
  - With addr upper bits all 1s, ram_addr passes them through unchanged; there is no wrap logic.

Test Plan:
- Reset mid-SB:
  - Stimulus: reset asserted during RMW_RD.
  - Required: ram_we never pulses, state returns to IDLE, req_ready=1 after release, and the RAM word is unchanged.
- SW then LW:
  - Stimulus: SW addr=0x10 data=0xDEADBEEF, then LW 0x10.
  - Required: one ram_we pulse with ram_addr=0x10; the load returns load_data=0xDEADBEEF two cycles after its handshake.
- Byte loads:
  - Setup: word 0x10 = 0x80FF7F01, BIG_ENDIAN=0.
  - LB 0x13 returns 0xFFFFFF80.
  - LBU 0x13 returns 0x00000080.
  - LB 0x11 returns 0x0000007F.
- Halfword loads:
  - LH 0x12 returns 0xFFFF80FF.
  - LHU 0x12 returns 0x000080FF.
  - LH 0x10 returns 0x00007F01.
- Read-modify-write stores:
  - SB 0x11 with data 0xAB gives word 0x80FFAB01.
  - SH 0x12 with data 0x1234 gives word 0x1234AB01.
  - Each completes in 3 cycles with exactly one ram_we pulse.
- Misalignment:
  - LW 0x11, SH 0x13 and LH 0x01 each give resp_valid with addr_err=1 one cycle after the handshake.
  - No ram_we pulse and memory unchanged.
